// File: rtl/spike_event_encoder.sv
// Timestamps spike activity from the LIF network and buffers events in a FIFO
// behind a valid/ready stream, counting any events lost to a full buffer.
module spike_event_encoder #(
    parameter int unsigned TS_W   = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [3:0]                 spike_in,
    input  logic                       out_ready,
    input  logic                       clear_ovf,
    output logic                       out_valid,
    output logic [TS_W+4:0]            out_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = TS_W + 5;

    logic [TS_W-1:0] ts;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            ts_last;
    logic            full;
    logic            push_req;
    logic            pop;
    logic            accept;
    logic            drop;

    assign ts_last  = (ts == '1);
    assign full     = (fifo_level == (AW+1)'(DEPTH));
    assign push_req = enable && ((spike_in != 4'b0000) || ts_last);
    assign out_valid = (fifo_level != '0);
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign accept   = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign out_data = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {ts_last, spike_in, ts};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (enable) begin
                ts <= ts + 1'b1;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !accept) begin
                fifo_level <= fifo_level - 1'b1;
            end
            // A drop on the clearing edge takes priority and counts as the first drop.
            if (drop) begin
                overflow <= 1'b1;
                if (clear_ovf) begin
                    drop_count <= DROP_W'(1);
                end else if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end else if (clear_ovf) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

endmodule
